// File: rtl/jk_ff_beh.sv
// ---------------------------------------------------------------------------
// jk_ff_beh : bank of WIDTH independent rising-edge JK flip-flops, sync reset
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_ff_beh #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;

  // Characteristic equation: 00 hold, 01 clear, 10 set, 11 toggle, per bit.
  always_comb begin
    q_next = (j & ~q_r) | (~k & q_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= q_next;
    end
  end

  assign q  = q_r;
  assign qn = ~q_r;

endmodule

`default_nettype wire

// File: tb/tb_jk_ff_beh.sv
// Directed bench for jk_ff_beh: single-bit (both reset values) and 4-bit bank.
`default_nettype none

module tb_jk_ff_beh;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, j_a = 1'b0, k_a = 1'b0;
  logic       q_a, qn_a;
  logic       rst_b = 1'b0, j_b = 1'b0, k_b = 1'b0;
  logic       q_b, qn_b;
  logic       rst_c = 1'b0;
  logic [3:0] j_c = 4'b0000, k_c = 4'b0000;
  logic [3:0] q_c, qn_c;

  int total = 0;
  int bad   = 0;

  always #3 clk = ~clk;

  jk_ff_beh #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .j(j_a), .k(k_a), .q(q_a), .qn(qn_a)
  );

  jk_ff_beh #(.WIDTH(1), .RESET_VAL(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .j(j_b), .k(k_b), .q(q_b), .qn(qn_b)
  );

  jk_ff_beh #(.WIDTH(4), .RESET_VAL(4'b0011)) dut_c (
    .clk(clk), .rst(rst_c), .j(j_c), .k(k_c), .q(q_c), .qn(qn_c)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with j=k=1 must still load RESET_VAL
    rst_a = 1'b1; j_a = 1'b1; k_a = 1'b1;
    rst_b = 1'b1; j_b = 1'b1; k_b = 1'b1;
    rst_c = 1'b1; j_c = 4'b1111; k_c = 4'b1111;
    tick();
    check("rst0_q",  {3'b000, q_a},  4'b0000);
    check("rst0_qn", {3'b000, qn_a}, 4'b0001);
    check("rst1_q",  {3'b000, q_b},  4'b0001);
    check("rst1_qn", {3'b000, qn_b}, 4'b0000);
    check("rstw_q",  q_c,  4'b0011);
    check("rstw_qn", qn_c, 4'b1100);

    // Hold / clear / set
    rst_a = 1'b0; j_a = 1'b0; k_a = 1'b0;
    rst_b = 1'b0; j_b = 1'b0; k_b = 1'b0;
    rst_c = 1'b0; j_c = 4'b1010; k_c = 4'b0110;
    tick();
    check("hold_q",   {3'b000, q_a},  4'b0000);
    check("hold1_q",  {3'b000, q_b},  4'b0001);
    check("bank_q",   q_c,  4'b1001);
    check("bank_qn",  qn_c, 4'b0110);
    j_c = 4'b0000; k_c = 4'b0000;
    j_a = 1'b0; k_a = 1'b1;
    tick();
    check("clr_q",    {3'b000, q_a},  4'b0000);
    check("bank_hold", q_c, 4'b1001);
    j_a = 1'b1; k_a = 1'b0;
    tick();
    check("set_q",    {3'b000, q_a},  4'b0001);
    check("set_qn",   {3'b000, qn_a}, 4'b0000);

    // Toggle from q=1
    j_a = 1'b1; k_a = 1'b1;
    tick();
    check("tog1_q",   {3'b000, q_a},  4'b0000);
    check("tog1_qn",  {3'b000, qn_a}, 4'b0001);
    tick();
    check("tog2_q",   {3'b000, q_a},  4'b0001);
    #2;
    check("tog2_mid", {3'b000, q_a},  4'b0001);
    tick();
    check("tog3_q",   {3'b000, q_a},  4'b0000);
    tick();
    check("tog4_q",   {3'b000, q_a},  4'b0001);

    // Reset priority mid-toggle, then resume from RESET_VAL
    rst_a = 1'b1;
    tick();
    check("rstmid_q",  {3'b000, q_a},  4'b0000);
    check("rstmid_qn", {3'b000, qn_a}, 4'b0001);
    rst_a = 1'b0;
    tick();
    check("resume_q",  {3'b000, q_a},  4'b0001);

    // Clear, then a j pulse between edges must not reach q
    j_a = 1'b0; k_a = 1'b1;
    tick();
    check("clr2_q",    {3'b000, q_a},  4'b0000);
    k_a = 1'b0;
    #1 j_a = 1'b1;
    #1;
    check("pulse_mid", {3'b000, q_a},  4'b0000);
    #1 j_a = 1'b0;
    tick();
    check("pulse_q",   {3'b000, q_a},  4'b0000);
    check("pulse_qn",  {3'b000, qn_a}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
